// File: rtl/stage_done_responder_pkg.sv
// Shared types and constants for the stage start/done responder.
package ctl_tb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } stage_st_e;

    // Feedback taps for x^8+x^6+x^5+x^4+1 on a left-shifting Fibonacci LFSR
    // (register bits 7,5,4,3 feed the new LSB).
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/stage_done_responder_lfsr8.sv
// 8-bit Fibonacci LFSR used as the latency jitter source; advances only when stepped.
module tb_lfsr8
    import ctl_tb_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       step_i,
    output logic [7:0] lfsr_o
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    // Next value: shift left, new LSB is the parity of the tapped bits.
    always_comb begin
        lfsr_d = lfsr_q;
        if (step_i) begin
            lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    // Register with synchronous reload of the seed.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/stage_done_responder.sv
// Stage-side responder for the sequencer start/done handshake: models compute
// latency from the job level, holds done until the next start, flags protocol errors.
module stage_done_responder
    import ctl_tb_pkg::*;
#(
    parameter int unsigned LEVEL_WIDTH   = 4,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned BASE_LAT      = 3,
    parameter int unsigned LAT_PER_LEVEL = 2,
    parameter logic [7:0]  JITTER_MASK   = 8'h00,
    parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start,
    input  logic                   i_switch_mode,
    input  logic [LEVEL_WIDTH-1:0] i_level,
    output logic                   o_done,
    output logic                   o_busy,
    output logic [LEVEL_WIDTH-1:0] o_level_q,
    output logic [CNT_W-1:0]       o_job_cnt,
    output logic [CNT_W-1:0]       o_switch_cnt,
    output logic                   o_err
);

    localparam int unsigned LW = CNT_W + 1;

    stage_st_e              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [LEVEL_WIDTH-1:0] level_q, level_d;
    logic [CNT_W-1:0]       job_q, job_d;
    logic [CNT_W-1:0]       sw_q, sw_d;
    logic                   err_q, err_d;

    logic       lfsr_step;
    logic [7:0] lfsr_val;
    logic [LW-1:0]    lat_full;
    logic [CNT_W-1:0] lat;
    logic             busy;
    logic             accept;

    tb_lfsr8 #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .step_i(lfsr_step),
        .lfsr_o(lfsr_val)
    );

    // Latency uses the jitter value present in the start cycle; one guard bit
    // detects overflow so the result saturates instead of wrapping.
    assign lat_full = LW'(BASE_LAT) + LW'(i_level) * LW'(LAT_PER_LEVEL)
                    + LW'(lfsr_val & JITTER_MASK);
    assign lat      = lat_full[CNT_W] ? '1 : lat_full[CNT_W-1:0];

    assign busy   = (state_q == ST_BUSY);
    assign accept = i_start && !busy;

    // Next-state: countdown in BUSY, job acceptance, counters and sticky error.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        job_d     = job_q;
        sw_d      = sw_q;
        err_d     = err_q;
        lfsr_step = 1'b0;

        case (state_q)
            ST_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            default: ;
        endcase

        if (accept) begin
            level_d   = i_level;
            job_d     = job_q + CNT_W'(1);
            lfsr_step = 1'b1;
            if (lat == CNT_W'(1)) begin
                state_d = ST_DONE;
            end else begin
                state_d = ST_BUSY;
                cnt_d   = lat - CNT_W'(1);
            end
        end

        if (i_start && busy) begin
            err_d = 1'b1;
        end

        if (i_switch_mode) begin
            sw_d = sw_q + CNT_W'(1);
            if (busy) begin
                err_d = 1'b1;
            end
        end
    end

    // State and counter registers; reset aborts any job in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            level_q <= '0;
            job_q   <= '0;
            sw_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            job_q   <= job_d;
            sw_q    <= sw_d;
            err_q   <= err_d;
        end
    end

    assign o_busy       = (state_q == ST_BUSY);
    assign o_done       = (state_q == ST_DONE);
    assign o_level_q    = level_q;
    assign o_job_cnt    = job_q;
    assign o_switch_cnt = sw_q;
    assign o_err        = err_q;

endmodule

// File: tb/tb_stage_done_responder.sv
// Self-checking bench for stage_done_responder: vector table, directed
// multi-cycle sequences, and randomized traffic against a timestamp model.
module tb_stage_done_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default parameters
    logic        rst_a = 1'b0, start_a = 1'b0, sw_a = 1'b0;
    logic [3:0]  level_a = '0;
    logic        done_a, busy_a, err_a;
    logic [3:0]  lvl_a;
    logic [15:0] job_a, swc_a;

    // Instance B: single-cycle latency
    logic        rst_b = 1'b0, start_b = 1'b0, sw_b = 1'b0;
    logic [3:0]  level_b = '0;
    logic        done_b, busy_b, err_b;
    logic [3:0]  lvl_b;
    logic [15:0] job_b, swc_b;

    // Instance C: jitter enabled
    logic        rst_c = 1'b0, start_c = 1'b0, sw_c = 1'b0;
    logic [3:0]  level_c = '0;
    logic        done_c, busy_c, err_c;
    logic [3:0]  lvl_c;
    logic [15:0] job_c, swc_c;

    stage_done_responder u_a (
        .clk(clk), .rst(rst_a), .i_start(start_a), .i_switch_mode(sw_a), .i_level(level_a),
        .o_done(done_a), .o_busy(busy_a), .o_level_q(lvl_a), .o_job_cnt(job_a),
        .o_switch_cnt(swc_a), .o_err(err_a)
    );

    stage_done_responder #(.BASE_LAT(1), .LAT_PER_LEVEL(0)) u_b (
        .clk(clk), .rst(rst_b), .i_start(start_b), .i_switch_mode(sw_b), .i_level(level_b),
        .o_done(done_b), .o_busy(busy_b), .o_level_q(lvl_b), .o_job_cnt(job_b),
        .o_switch_cnt(swc_b), .o_err(err_b)
    );

    stage_done_responder #(.JITTER_MASK(8'h07)) u_c (
        .clk(clk), .rst(rst_c), .i_start(start_c), .i_switch_mode(sw_c), .i_level(level_c),
        .o_done(done_c), .o_busy(busy_c), .o_level_q(lvl_c), .o_job_cnt(job_c),
        .o_switch_cnt(swc_c), .o_err(err_c)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    // Pulse start on C from IDLE/DONE; return cycles until done is first seen.
    task automatic measure_c(input logic [3:0] lv, output int lat);
        start_c = 1'b1;
        level_c = lv;
        step();
        start_c = 1'b0;
        lat = 1;
        while (!done_c && lat < 100) begin
            step();
            lat++;
        end
    endtask

    task automatic wait_done_a(output int lat, input int start_at);
        lat = start_at;
        while (!done_a && lat < 100) begin
            step();
            lat++;
        end
    endtask

    task automatic reset_a();
        rst_a = 1'b1; start_a = 1'b0; sw_a = 1'b0; level_a = '0;
        step();
        rst_a = 1'b0;
    endtask

    typedef struct {
        logic        start;
        logic        sw;
        logic [3:0]  level;
        logic        done;
        logic        busy;
        logic [15:0] job;
        logic [15:0] swc;
        logic        err;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int cnt;
        int lat_run1[100];
        logic [3:0] lv_tab[100];
        logic [7:0] m_lfsr;
        int lat0;
        int want;

        // Each row: inputs for one cycle, outputs expected after that edge.
        tbl[0] = '{1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 16'd1, 16'd0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 16'd1, 16'd0, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 16'd1, 16'd0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 16'd1, 16'd1, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 16'd1, 16'd1, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 4'd1, 1'b0, 1'b1, 16'd2, 16'd1, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 16'd2, 16'd2, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 16'd2, 16'd2, 1'b1};

        // Reset state on all instances
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        step();
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        chk("rst_done", done_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_lvl", lvl_a, 0);
        chk("rst_job", job_a, 0);
        chk("rst_swc", swc_a, 0);
        chk("rst_err", err_a, 0);

        for (int i = 0; i < 8; i++) begin
            start_a = tbl[i].start; sw_a = tbl[i].sw; level_a = tbl[i].level;
            step();
            start_a = 1'b0; sw_a = 1'b0;
            chk($sformatf("tbl%0d_done", i), done_a, tbl[i].done);
            chk($sformatf("tbl%0d_busy", i), busy_a, tbl[i].busy);
            chk($sformatf("tbl%0d_job", i), job_a, tbl[i].job);
            chk($sformatf("tbl%0d_swc", i), swc_a, tbl[i].swc);
            chk($sformatf("tbl%0d_err", i), err_a, tbl[i].err);
        end

        // Level 0: done at T+3, held 20 cycles
        reset_a();
        start_a = 1'b1; level_a = 4'd0;
        step();
        start_a = 1'b0;
        wait_done_a(lat, 1);
        chk("t1_lat", lat, 3);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done_a) cnt++;
        end
        chk("t1_hold", cnt, 20);
        chk("t1_job", job_a, 1);

        // Level 4: 11 cycles, restart from DONE
        start_a = 1'b1; level_a = 4'd4;
        step();
        start_a = 1'b0;
        chk("t2_lvl", lvl_a, 4);
        wait_done_a(lat, 1);
        chk("t2_lat", lat, 11);
        start_a = 1'b1; level_a = 4'd4;
        step();
        start_a = 1'b0;
        chk("t2_drop", done_a, 0);
        wait_done_a(lat, 1);
        chk("t2_lat2", lat, 11);
        chk("t2_job", job_a, 3);
        chk("t2_err", err_a, 0);

        // Start while busy is ignored and sets sticky error
        reset_a();
        start_a = 1'b1; level_a = 4'd4;
        step();
        start_a = 1'b0;
        step();
        start_a = 1'b1; level_a = 4'd9;
        step();
        start_a = 1'b0;
        chk("t4_err", err_a, 1);
        chk("t4_lvl", lvl_a, 4);
        chk("t4_job", job_a, 1);
        chk("t4_busy", busy_a, 1);
        wait_done_a(lat, 3);
        chk("t4_lat", lat, 11);
        for (int i = 0; i < 5; i++) step();
        chk("t4_sticky", err_a, 1);

        // switch_mode in IDLE is counted only; in BUSY it also sets error
        reset_a();
        sw_a = 1'b1;
        step();
        sw_a = 1'b0;
        chk("t4_sw_idle_cnt", swc_a, 1);
        chk("t4_sw_idle_err", err_a, 0);
        start_a = 1'b1; level_a = 4'd4;
        step();
        start_a = 1'b0; sw_a = 1'b1;
        step();
        sw_a = 1'b0;
        chk("t4_sw_busy_cnt", swc_a, 2);
        chk("t4_sw_busy_err", err_a, 1);

        // Reset mid-job aborts with no done
        reset_a();
        start_a = 1'b1; level_a = 4'd4;
        step();
        start_a = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        chk("t5_done", done_a, 0);
        chk("t5_busy", busy_a, 0);
        chk("t5_lvl", lvl_a, 0);
        chk("t5_job", job_a, 0);
        chk("t5_swc", swc_a, 0);
        chk("t5_err", err_a, 0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done_a || busy_a) cnt++;
        end
        chk("t5_quiet", cnt, 0);

        // Single-cycle latency: back-to-back starts keep done high
        start_b = 1'b1;
        for (int i = 0; i < 6; i++) begin
            level_b = 4'($urandom_range(15));
            step();
            chk("t3_done", done_b, 1);
            chk("t3_busy", busy_b, 0);
            chk("t3_job", job_b, i + 1);
            chk("t3_lvl", lvl_b, level_b);
        end
        start_b = 1'b0;
        step();
        chk("t3_hold", done_b, 1);
        chk("t3_err", err_b, 0);

        // Jitter: exact latency from polynomial, inside window, reproducible
        m_lfsr = 8'hA5;
        for (int j = 0; j < 100; j++) begin
            lv_tab[j] = 4'($urandom_range(15));
            lat0 = 3 + 2 * int'(lv_tab[j]);
            want = lat0 + int'(m_lfsr & 8'h07);
            m_lfsr = lfsr_next(m_lfsr);
            measure_c(lv_tab[j], lat);
            lat_run1[j] = lat;
            chk("t6_lat", lat, want);
            chk("t6_window", (lat >= lat0 && lat <= lat0 + 7) ? 1 : 0, 1);
        end
        chk("t6_jobs", job_c, 100);
        rst_c = 1'b1;
        step();
        rst_c = 1'b0;
        for (int j = 0; j < 100; j++) begin
            measure_c(lv_tab[j], lat);
            chk("t6_repeat", lat, lat_run1[j]);
        end

        // Randomized traffic on A against a timestamp model
        begin
            longint m_cyc;
            longint m_done_cyc;
            bit     m_active;
            bit     m_busy;
            int     m_job, m_swc;
            bit     m_err;
            logic [3:0] m_lvl;
            bit r_start, r_sw, r_rst;
            logic [3:0] r_lvl;

            reset_a();
            m_cyc = 0; m_done_cyc = 0; m_active = 0;
            m_job = 0; m_swc = 0; m_err = 0; m_lvl = '0;
            for (int k = 0; k < 2500; k++) begin
                r_start = ($urandom_range(5) == 0);
                r_sw    = ($urandom_range(15) == 0);
                r_rst   = ($urandom_range(299) == 0);
                r_lvl   = 4'($urandom_range(15));
                start_a = r_start; sw_a = r_sw; rst_a = r_rst; level_a = r_lvl;

                m_busy = m_active && (m_cyc < m_done_cyc);
                if (r_rst) begin
                    m_active = 0; m_job = 0; m_swc = 0; m_err = 0; m_lvl = '0;
                end else begin
                    if (r_start) begin
                        if (m_busy) begin
                            m_err = 1;
                        end else begin
                            m_lvl = r_lvl;
                            m_job = (m_job + 1) % 65536;
                            m_active = 1;
                            m_done_cyc = m_cyc + 3 + 2 * longint'(r_lvl);
                        end
                    end
                    if (r_sw) begin
                        m_swc = (m_swc + 1) % 65536;
                        if (m_busy) m_err = 1;
                    end
                end

                step();
                m_cyc++;
                chk("rnd_done", done_a, (m_active && m_cyc >= m_done_cyc) ? 1 : 0);
                chk("rnd_busy", busy_a, (m_active && m_cyc < m_done_cyc) ? 1 : 0);
                chk("rnd_lvl", lvl_a, m_lvl);
                chk("rnd_job", job_a, m_job);
                chk("rnd_swc", swc_a, m_swc);
                chk("rnd_err", err_a, m_err);
            end
            start_a = 1'b0; sw_a = 1'b0; rst_a = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
